seg7_scan_display: RTL



---
 rtl/seg7_scan_display.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seg7_scan_display.sv
// Multiplexed 7-segment scanner with frame-coherent digit latch, edit blink and colon flash.
// Optional anode ghost blanking at the start of each slot: define SEG7_GHOST_BLANK_EN.
module seg7_scan_display #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 250,
  parameter int BLANK_CYC    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [1:0]              edit_field,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SW-1:0]           r_scan_cnt;
  logic [DW-1:0]           r_digit_idx;
  logic [FW-1:0]           r_frame_cnt;
  logic                    r_blink_phase;
  logic                    r_phase_lat;
  logic                    r_live;
  logic [4*NUM_DIGITS-1:0] r_bcd;
  logic [1:0]              r_edit;

  logic                    w_latch;
  logic                    w_wrap;
  logic [4*NUM_DIGITS-1:0] w_bcd;
  logic [1:0]              w_edit;
  logic                    w_phase;
  logic [3:0]              w_nib;
  logic [6:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_an;
  logic                    w_dp;
  logic                    w_blank;

  assign w_latch = (r_digit_idx == '0) && (r_scan_cnt == '0);
  assign w_wrap  = (r_scan_cnt == SW'(SCAN_DIV - 1));

  // On the latch cycle show the values being captured so digit 0 never tears
  assign w_bcd   = w_latch ? bcd_in : r_bcd;
  assign w_edit  = w_latch ? edit_field : r_edit;
  assign w_phase = w_latch ? r_blink_phase : r_phase_lat;
  assign w_nib   = w_bcd[{r_digit_idx, 2'b00} +: 4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= '0;
    end else if (w_wrap) begin
      r_scan_cnt  <= '0;
      if (r_digit_idx == DW'(NUM_DIGITS - 1))
        r_digit_idx <= '0;
      else
        r_digit_idx <= r_digit_idx + 1'b1;
    end else begin
      r_scan_cnt  <= r_scan_cnt + 1'b1;
    end
  end

  // Blink phase toggles at a latch and is shown from the following frame on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_phase_lat   <= 1'b0;
      r_bcd         <= '0;
      r_edit        <= '0;
    end else if (w_latch) begin
      r_bcd       <= bcd_in;
      r_edit      <= edit_field;
      r_phase_lat <= r_blink_phase;
      if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt   <= r_frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    case (w_nib)
      4'd0:    w_seg = 7'h40;
      4'd1:    w_seg = 7'h79;
      4'd2:    w_seg = 7'h24;
      4'd3:    w_seg = 7'h30;
      4'd4:    w_seg = 7'h19;
      4'd5:    w_seg = 7'h12;
      4'd6:    w_seg = 7'h02;
      4'd7:    w_seg = 7'h78;
      4'd8:    w_seg = 7'h00;
      4'd9:    w_seg = 7'h10;
      default: w_seg = 7'h7F;
    endcase
  end

  always_comb begin
    w_blank = w_phase && (w_edit != 2'd0) &&
              ((int'(r_digit_idx) / 2 + 1) == int'(w_edit));
`ifdef SEG7_GHOST_BLANK_EN
    if (int'(r_scan_cnt) < BLANK_CYC)
      w_blank = 1'b1;
`endif
    w_an = '1;
    if (!w_blank)
      w_an[r_digit_idx] = 1'b0;
    w_dp = !(((int'(r_digit_idx) == 2) || (int'(r_digit_idx) == 4)) && !w_phase);
  end

  // r_live holds outputs dark for the latch cycle right after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;
      an     <= '1;
      seg    <= 7'h7F;
      dp     <= 1'b1;
    end else begin
      r_live <= 1'b1;
      if (r_live) begin
        an  <= w_an;
        seg <= w_seg;
        dp  <= w_dp;
      end
    end
  end

endmodule
